// File: rtl/vm_pkg.sv
// Shared state encoding, coin codes and coin value helper for the change dispenser.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAY   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  function automatic logic [1:0] coin_val(input logic [1:0] code);
    case (code)
      COIN_1:  return 2'd1;
      COIN_2:  return 2'd2;
      COIN_3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_ack_timer.sv
// Watchdog on the hopper handshake: counts unacked cycles while a coin is presented.
module vm_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] count;

  // Holds at LAST once reached; the owner leaves PAY on that cycle anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays a loaded credit back to the hopper largest coin first,
// one coin per valid/ack handshake, with a watchdog that faults on a stalled hopper.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W    = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit_in,
  input  logic                clear,
  input  logic                coin_ack,
  output logic [1:0]          coin_out,
  output logic                coin_valid,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [CREDIT_W-1:0] remaining,
  output logic [1:0]          out_state
);

  state_t              state;
  logic [CREDIT_W-1:0] rem_q;
  logic [1:0]          coin_code;
  logic [CREDIT_W-1:0] coin_units;
  logic                in_pay;
  logic                timer_clr;
  logic                timer_expired;

  assign in_pay     = (state == PAY);
  assign coin_code  = (rem_q >= CREDIT_W'(3)) ? COIN_3 : rem_q[1:0];
  assign coin_units = CREDIT_W'(coin_val(coin_code));
  assign timer_clr  = !in_pay || coin_ack;

  vm_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (in_pay),
    .expired(timer_expired)
  );

  // An ack on the expiry cycle is checked first, so a late hopper still gets credit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (credit_in != '0) begin
              state <= PAY;
              rem_q <= credit_in;
            end else begin
              state <= DONE;
            end
          end
        end
        PAY: begin
          if (coin_ack) begin
            rem_q <= rem_q - coin_units;
            if (rem_q == coin_units) begin
              state <= DONE;
            end
          end else if (timer_expired) begin
            state <= FAULT;
          end
        end
        DONE: begin
          state <= IDLE;
          rem_q <= '0;
        end
        FAULT: begin
          if (clear) begin
            state <= IDLE;
            rem_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          rem_q <= '0;
        end
      endcase
    end
  end

  assign coin_out   = in_pay ? coin_code : COIN_NONE;
  assign coin_valid = in_pay;
  assign busy       = in_pay;
  assign done       = (state == DONE);
  assign fault      = (state == FAULT);
  assign remaining  = rem_q;
  assign out_state  = state;

endmodule
